// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key-locked counter controller: FSM state encoding
// and the default key width used by both the controller and the counter.
package key_ctrl_pkg;

    localparam int KEY_SIZE_DEF      = 4;
    localparam int SETTLE_CYCLES_DEF = 3;
    localparam int PERIOD_W_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        APPLY = 2'd2,
        RUN   = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_shift_reg.sv
// Serial key shadow register with bit counter. The shadow output already
// includes the bit being accepted this cycle, so the controller can apply the
// complete key on the same edge that takes in the final bit.
module key_shift_reg
    import key_ctrl_pkg::*;
#(
    parameter int KEY_SIZE = KEY_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                shift_en,
    input  logic                key_bit,
    output logic [KEY_SIZE-1:0] shadow,
    output logic                done
);

    localparam int CW = (KEY_SIZE > 2) ? $clog2(KEY_SIZE) : 1;

    logic [KEY_SIZE-1:0] shadow_q;
    logic [CW-1:0]       bit_cnt;

    assign shadow = shift_en ? {shadow_q[KEY_SIZE-2:0], key_bit} : shadow_q;
    assign done   = shift_en && (bit_cnt == CW'(KEY_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shadow_q <= '0;
            bit_cnt  <= '0;
        end else if (shift_en) begin
            shadow_q <= shadow;
            bit_cnt  <= done ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/key_seq_ctrl.sv
// Key load / apply / step / periodic-run sequencer for the key-locked counter.
// Owns the applied key register and the increment strobe; all outputs are flops.
module key_seq_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int KEY_SIZE      = KEY_SIZE_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int PERIOD_W      = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                key_bit,
    input  logic                key_bit_valid,
    input  logic                step,
    input  logic                run_start,
    input  logic                run_stop,
    input  logic [PERIOD_W-1:0] period,
    output logic [KEY_SIZE-1:0] key_out,
    output logic                do_incr,
    output logic                ctr_clear,
    output logic                key_loaded,
    output logic                busy,
    output key_state_e          dbg_state
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    key_state_e          state, state_next;
    logic [SW-1:0]       settle_cnt, settle_next;
    logic [PERIOD_W-1:0] run_cnt, run_cnt_next;
    logic [PERIOD_W-1:0] period_q, period_next;

    logic                shift_clear, shift_en, shift_done;
    logic [KEY_SIZE-1:0] shadow;
    logic                step_fire, apply_enter, apply_exit, do_incr_d;

    // Handshake: key_bit is consumed on every cycle key_bit_valid is high while
    // in LOAD (no backpressure); a load_start in the same cycle wins and the bit
    // is dropped.
    assign shift_clear = load_start && ((state == IDLE) || (state == LOAD) || (state == RUN));
    assign shift_en    = (state == LOAD) && key_bit_valid && !load_start;

    key_shift_reg #(
        .KEY_SIZE (KEY_SIZE)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (shift_clear),
        .shift_en (shift_en),
        .key_bit  (key_bit),
        .shadow   (shadow),
        .done     (shift_done)
    );

    always_comb begin
        state_next   = state;
        settle_next  = settle_cnt;
        run_cnt_next = run_cnt;
        period_next  = period_q;
        step_fire    = 1'b0;
        apply_enter  = 1'b0;
        apply_exit   = 1'b0;

        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end else if (run_start && key_loaded) begin
                    state_next   = RUN;
                    run_cnt_next = '0;
                    period_next  = period;
                end else if (step && key_loaded) begin
                    step_fire = 1'b1;
                end
            end
            LOAD: begin
                if (shift_done) begin
                    state_next  = APPLY;
                    settle_next = '0;
                    apply_enter = 1'b1;
                end
            end
            APPLY: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    state_next = IDLE;
                    apply_exit = 1'b1;
                end else begin
                    settle_next = settle_cnt + SW'(1);
                end
            end
            RUN: begin
                if (load_start) begin
                    state_next = LOAD;
                end else if (run_stop) begin
                    state_next = IDLE;
                end else begin
                    run_cnt_next = (run_cnt == period_q) ? '0 : run_cnt + PERIOD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // The pulse is registered, so it is decided from the counter value the
        // next cycle will hold; this lands the first pulse P+1 cycles after run_start.
        do_incr_d = step_fire || ((state_next == RUN) && (run_cnt_next == period_next));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            run_cnt    <= '0;
            period_q   <= '0;
            key_out    <= '0;
            do_incr    <= 1'b0;
            ctr_clear  <= 1'b0;
            key_loaded <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            run_cnt    <= run_cnt_next;
            period_q   <= period_next;
            if (apply_enter) begin
                key_out <= shadow;
            end
            do_incr    <= do_incr_d;
            ctr_clear  <= apply_enter;
            key_loaded <= key_loaded || apply_exit;
            busy       <= (state_next != IDLE);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_key_seq_ctrl.sv
// Directed bench for key_seq_ctrl (KEY_SIZE=4, SETTLE_CYCLES=3, PERIOD_W=4).
module tb_key_seq_ctrl;
    import key_ctrl_pkg::*;

    localparam int KS = 4;
    localparam int SC = 3;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          key_bit = 1'b0;
    logic          key_bit_valid = 1'b0;
    logic          step = 1'b0;
    logic          run_start = 1'b0;
    logic          run_stop = 1'b0;
    logic [PW-1:0] period = '0;
    logic [KS-1:0] key_out;
    logic          do_incr;
    logic          ctr_clear;
    logic          key_loaded;
    logic          busy;
    key_state_e    dbg_state;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [0:0] exp_q[$];

    key_seq_ctrl #(
        .KEY_SIZE      (KS),
        .SETTLE_CYCLES (SC),
        .PERIOD_W      (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .key_bit       (key_bit),
        .key_bit_valid (key_bit_valid),
        .step          (step),
        .run_start     (run_start),
        .run_stop      (run_stop),
        .period        (period),
        .key_out       (key_out),
        .do_incr       (do_incr),
        .ctr_clear     (ctr_clear),
        .key_loaded    (key_loaded),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver tasks: each tick advances one cycle; outputs are read 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        key_bit_valid = 1'b1;
        key_bit       = b;
        tick();
        key_bit_valid = 1'b0;
        key_bit       = 1'b0;
    endtask

    task automatic load_key(input logic [KS-1:0] k);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = KS - 1; i >= 0; i--) send_bit(k[i]);
        repeat (SC) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key_out"}, 32'(key_out), 0);
        check({tag, "_do_incr"}, 32'(do_incr), 0);
        check({tag, "_ctr_clear"}, 32'(ctr_clear), 0);
        check({tag, "_key_loaded"}, 32'(key_loaded), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        logic [KS-1:0] k;
        int pulses;

        // reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_start    = 1'($urandom_range(0, 1));
            key_bit       = 1'($urandom_range(0, 1));
            key_bit_valid = 1'($urandom_range(0, 1));
            step          = 1'($urandom_range(0, 1));
            run_start     = 1'($urandom_range(0, 1));
            run_stop      = 1'($urandom_range(0, 1));
            period        = PW'($urandom_range(0, 15));
            tick();
        end
        check_all_zero("reset");
        rst = 1'b0; load_start = 0; key_bit = 0; key_bit_valid = 0;
        step = 0; run_start = 0; run_stop = 0; period = '0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_unloaded", 32'(do_incr), 0);
        run_start = 1'b1; period = 4'd2;
        tick();
        run_start = 1'b0;
        check("run_unloaded_state", 32'(dbg_state), 32'(IDLE));
        check("run_unloaded_busy", 32'(busy), 0);

        // load 1011 with gaps between bits
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_busy", 32'(busy), 1);
        check("load_state", 32'(dbg_state), 32'(LOAD));
        k = 4'b1011;
        for (int i = KS - 1; i >= 0; i--) begin
            tick();
            send_bit(k[i]);
            if (i != 0) begin
                check("load_key_hold", 32'(key_out), 0);
                check("load_no_clear", 32'(ctr_clear), 0);
            end
        end
        check("apply_state", 32'(dbg_state), 32'(APPLY));
        check("apply_clear", 32'(ctr_clear), 1);
        check("apply_key", 32'(key_out), 32'hB);
        tick();
        check("apply_clear_once", 32'(ctr_clear), 0);
        check("apply_incr_held", 32'(do_incr), 0);
        tick();
        check("apply_not_loaded", 32'(key_loaded), 0);
        check("apply_busy", 32'(busy), 1);
        tick();
        check("loaded_flag", 32'(key_loaded), 1);
        check("loaded_busy", 32'(busy), 0);
        check("loaded_state", 32'(dbg_state), 32'(IDLE));

        // single step: one-cycle pulse on the next cycle
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_pulse", 32'(do_incr), 1);
        tick();
        check("step_pulse_end", 32'(do_incr), 0);

        // restart mid-load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        k = 4'b0110;
        for (int i = KS - 1; i >= 0; i--) begin
            send_bit(k[i]);
            if (i != 0) begin
                check("restart_no_incr", 32'(do_incr), 0);
                check("restart_no_clear", 32'(ctr_clear), 0);
                check("restart_key_hold", 32'(key_out), 32'hB);
            end
        end
        check("restart_clear", 32'(ctr_clear), 1);
        check("restart_key", 32'(key_out), 32'h6);
        repeat (SC) tick();
        check("restart_idle", 32'(dbg_state), 32'(IDLE));

        // periodic run, P=3: pulses at +4, +8, +12; step ignored in RUN
        for (int c = 1; c <= 14; c++) exp_q.push_back(1'((c % 4) == 0));
        period = 4'd3;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        period = 4'd9;
        check("run_busy", 32'(busy), 1);
        for (int c = 1; c <= 14; c++) begin
            check($sformatf("run_p3_c%0d", c), 32'(do_incr), 32'(exp_q.pop_front()));
            step     = (c == 2);
            run_stop = (c == 14);
            tick();
        end
        step = 1'b0; run_stop = 1'b0;
        check("stop_state", 32'(dbg_state), 32'(IDLE));
        check("stop_busy", 32'(busy), 0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            pulses += int'(do_incr);
            tick();
        end
        check("stop_no_pulses", 32'(pulses), 0);

        // P=0: continuous strobe
        period = 4'd0;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            pulses += int'(do_incr);
            tick();
        end
        check("run_p0_pulses", 32'(pulses), 5);

        // load_start + run_stop in RUN -> LOAD, no pulse
        load_start = 1'b1; run_stop = 1'b1;
        tick();
        load_start = 1'b0; run_stop = 1'b0;
        check("run_coll_state", 32'(dbg_state), 32'(LOAD));
        check("run_coll_incr", 32'(do_incr), 0);
        k = 4'b0011;
        for (int i = KS - 1; i >= 0; i--) send_bit(k[i]);
        check("reload_key", 32'(key_out), 32'h3);
        repeat (SC) tick();

        // load_start + run_start + step in IDLE -> LOAD, no pulse
        load_start = 1'b1; run_start = 1'b1; step = 1'b1; period = 4'd0;
        tick();
        load_start = 1'b0; run_start = 1'b0; step = 1'b0;
        check("idle_coll_state", 32'(dbg_state), 32'(LOAD));
        check("idle_coll_incr", 32'(do_incr), 0);
        tick();
        check("idle_coll_incr2", 32'(do_incr), 0);

        // reset mid-load after 2 of 4 bits
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midload_rst");
        tick();
        check("midload_rst_key", 32'(key_out), 0);

        // reset mid-run
        load_key(4'b1001);
        check("rerun_loaded", 32'(key_loaded), 1);
        period = 4'd0;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        tick();
        check("rerun_incr", 32'(do_incr), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst_incr", 32'(do_incr), 0);
        check("midrun_rst_state", 32'(dbg_state), 32'(IDLE));
        check("midrun_rst_key", 32'(key_out), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
